step_motor_sequencer: RTL and testbench

- Generates the four coil-phase signals (AX, AY, BX, BY) for one bipolar stepper channel.
- Its outputs drive the top-level port mapping directly; that mapping applies any per-driver inversion and enable tie-offs.
- A host-side register block supplies a move command: direction, full/half mode, step period and step count. The block runs the move autonomously and reports completion and position.
- One instance per motor channel (0..3).

---
 rtl/stepper_pkg.sv | 39 +++
 rtl/step_rate_divider.sv | 28 ++
 rtl/step_motor_sequencer.sv | 159 +++++++++++++++
 tb/tb_step_motor_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper channel: FSM states, coil phase table
// and the phase-index step rule.
package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int IDX_WIDTH  = 3;
    localparam int MIN_PERIOD = 2;

    localparam logic [IDX_WIDTH-1:0] RESET_IDX = 3'd1;

    // Entry n sits at bits [4n+3:4n]; bit order within an entry is AX,AY,BX,BY.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001,  // 7
        4'b0001,  // 6
        4'b0101,  // 5
        4'b0100,  // 4
        4'b0110,  // 3
        4'b0010,  // 2
        4'b1010,  // 1
        4'b1000   // 0
    };

    // Full mode from an even index moves by one so the next entry is a
    // two-coil (odd) entry; from there it moves by two.
    function automatic logic [IDX_WIDTH-1:0] step_index(
        input logic [IDX_WIDTH-1:0] idx,
        input logic                 fwd,
        input logic                 half
    );
        logic [IDX_WIDTH-1:0] delta;
        delta = (half || !idx[0]) ? 3'd1 : 3'd2;
        return fwd ? (idx + delta) : (idx - delta);
    endfunction

endpackage

// File: rtl/step_rate_divider.sv
// Loadable down-counter; terminal is high while the count sits at zero.
module step_rate_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/step_motor_sequencer.sv
// One bipolar stepper channel: runs a latched move command, producing
// registered coil phases, a busy flag, a done pulse and a signed position.
module step_motor_sequencer
    import stepper_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int STEPS_WIDTH  = 16,
    parameter int POS_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        dir,
    input  logic                        half_step,
    input  logic                        hold_en,
    input  logic [PERIOD_WIDTH-1:0]     period,
    input  logic [STEPS_WIDTH-1:0]      steps,
    output logic                        AX,
    output logic                        AY,
    output logic                        BX,
    output logic                        BY,
    output logic                        busy,
    output logic                        done,
    output logic signed [POS_WIDTH-1:0] position
);

    state_t state;
    state_t state_next;

    logic                    dir_q;
    logic                    half_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic [STEPS_WIDTH-1:0]  remaining;
    logic [IDX_WIDTH-1:0]    idx;
    logic [IDX_WIDTH-1:0]    idx_next;
    logic [3:0]              coils;
    logic [3:0]              coils_next;

    logic                    accept;
    logic                    take_step;
    logic                    done_set;
    logic                    div_load;
    logic                    div_dec;
    logic [PERIOD_WIDTH-1:0] div_value;
    logic                    div_zero;

    // Abort beats start in IDLE, so a simultaneous pair never launches a move.
    assign accept     = (state == IDLE) && start && !abort;
    assign period_eff = (period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period;

    step_rate_divider #(
        .WIDTH(PERIOD_WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (div_load),
        .load_value(div_value),
        .enable    (div_dec),
        .terminal  (div_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (steps != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort || (div_zero && (remaining == '0))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A step due in the same cycle as abort is dropped.
    always_comb begin
        take_step = 1'b0;
        done_set  = 1'b0;
        div_load  = 1'b0;
        div_dec   = 1'b0;
        div_value = '0;
        idx_next  = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    div_load = 1'b1;
                    done_set = (steps == '0);
                end
            end
            RUN: begin
                if (!abort) begin
                    if (div_zero) begin
                        if (remaining != '0) begin
                            take_step = 1'b1;
                            div_load  = 1'b1;
                            div_value = period_q - PERIOD_WIDTH'(1);
                            idx_next  = step_index(idx, dir_q, half_q);
                        end else begin
                            done_set = 1'b1;
                        end
                    end else begin
                        div_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        coils_next = ((state_next == RUN) || hold_en) ? PHASE_TABLE[idx_next] : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            period_q  <= PERIOD_WIDTH'(MIN_PERIOD);
            remaining <= '0;
            idx       <= RESET_IDX;
            position  <= '0;
            coils     <= 4'b0000;
            done      <= 1'b0;
        end else begin
            done  <= done_set;
            coils <= coils_next;
            idx   <= idx_next;
            if (accept) begin
                dir_q     <= dir;
                half_q    <= half_step;
                period_q  <= period_eff;
                remaining <= steps;
            end
            if (take_step) begin
                remaining <= remaining - STEPS_WIDTH'(1);
                if (dir_q) begin
                    position <= position + POS_WIDTH'(1);
                end else begin
                    position <= position - POS_WIDTH'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign {AX, AY, BX, BY} = coils;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Self-checking bench for step_motor_sequencer: per-scenario tasks, a
// scoreboard of expected phase updates, and a one-line summary.
module tb_step_motor_sequencer;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               abort;
    logic               dir;
    logic               half_step;
    logic               hold_en;
    logic [15:0]        period;
    logic [15:0]        steps;
    logic               AX;
    logic               AY;
    logic               BX;
    logic               BY;
    logic               busy;
    logic               done;
    logic signed [31:0] position;
    logic [3:0]         coils_obs;

    int total;
    int bad;

    // Expected phase updates: pattern, cycle after start, resulting index.
    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];
    int         exp_idx_q[$];

    int                 m_idx;
    logic signed [31:0] m_pos;
    bit                 cur_dir;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                            4'b0100, 4'b0101, 4'b0001, 4'b1001};

    assign coils_obs = {AX, AY, BX, BY};

    step_motor_sequencer #(
        .PERIOD_WIDTH(16),
        .STEPS_WIDTH (16),
        .POS_WIDTH   (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .dir      (dir),
        .half_step(half_step),
        .hold_en  (hold_en),
        .period   (period),
        .steps    (steps),
        .AX       (AX),
        .AY       (AY),
        .BX       (BX),
        .BY       (BY),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int bench_next(input int i, input bit fwd, input bit half);
        int d;
        d = (half || ((i % 2) == 0)) ? 1 : 2;
        return fwd ? ((i + d) % 8) : ((i + 8 - d) % 8);
    endfunction

    task automatic flush_sb();
        exp_q.delete();
        exp_cyc_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m_idx = 1;
        m_pos = '0;
        flush_sb();
    endtask

    // Driver: pushes the expected updates, then pulses start for one cycle.
    // Returns with the bench sitting in cycle T+1.
    task automatic drive_move(input bit d, input bit h, input int p, input int s,
                              input bit hold, output int done_cyc);
        int pe;
        int i;
        pe = (p < 2) ? 2 : p;
        i  = m_idx;
        for (int k = 0; k < s; k++) begin
            i = bench_next(i, d, h);
            exp_q.push_back(tbl[i]);
            exp_idx_q.push_back(i);
            exp_cyc_q.push_back(2 + k * pe);
        end
        done_cyc = (s == 0) ? 1 : 2 + s * pe;
        cur_dir  = d;
        @(negedge clk);
        dir       = d;
        half_step = h;
        period    = 16'(p);
        steps     = 16'(s);
        hold_en   = hold;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard: follows a move from T+1, popping an expectation for every
    // phase change, and stops on done (or one cycle after an abort).
    task automatic score_move(input int done_cyc, input int abort_cyc,
                              input int poke_cyc, input int budget);
        logic [3:0] prev;
        logic [3:0] cur;
        logic [3:0] e;
        int         ec;
        int         ei;
        bit         fin;
        fin  = 1'b0;
        prev = coils_obs;
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            if (cyc > 1) begin
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
            end
            cur = coils_obs;
            if (done === 1'b1) begin
                total++;
                if (cyc != done_cyc) begin
                    bad++;
                    $display("FAIL done_time: done at cycle %0d, required %0d", cyc, done_cyc);
                end
                fin = 1'b1;
            end else if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_busy: busy=%b, required 0", busy);
                end
                fin = 1'b1;
            end else if (cyc == 1) begin
                total++;
                if (cur !== tbl[m_idx]) begin
                    bad++;
                    $display("FAIL run_entry: coils=%b, required %b", cur, tbl[m_idx]);
                end
            end else if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_step: coils=%b at cycle %0d, none expected", cur, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (cur !== e || cyc != ec) begin
                        bad++;
                        $display("FAIL step: coils=%b at cycle %0d, required %b at cycle %0d",
                                 cur, cyc, e, ec);
                    end
                    m_idx = ei;
                    if (cur_dir) m_pos = m_pos + 32'sd1;
                    else         m_pos = m_pos - 32'sd1;
                end
            end
            prev = cur;
            if (!fin && cyc == abort_cyc) abort = 1'b1;
            if (!fin && cyc == poke_cyc) begin
                start     = 1'b1;
                dir       = ~dir;
                half_step = ~half_step;
                period    = 16'd1;
                steps     = 16'd7;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout: move did not finish within %0d cycles", budget);
        end else if (abort_cyc == 0) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL missing_steps: %0d updates never seen, required 0", exp_q.size());
            end
        end
        flush_sb();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hold_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total += 4;
        if (coils_obs !== 4'b0000) begin bad++; $display("FAIL reset_coils: %b, required 0000", coils_obs); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: %b, required 0", busy); end
        if (done !== 1'b0)         begin bad++; $display("FAIL reset_done: %b, required 0", done); end
        if (position !== 32'sd0)   begin bad++; $display("FAIL reset_pos: %0d, required 0", position); end
        reset_n = 1'b1;
        @(negedge clk);
        total += 3;
        if (coils_obs !== 4'b1010) begin bad++; $display("FAIL hold_idle: %b, required 1010", coils_obs); end
        if (position !== 32'sd0)   begin bad++; $display("FAIL idle_pos: %0d, required 0", position); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL idle_busy: %b, required 0", busy); end
        hold_en = 1'b0;
        @(negedge clk);
        total++;
        if (coils_obs !== 4'b0000) begin bad++; $display("FAIL hold_off: %b, required 0000", coils_obs); end
        m_idx = 1;
        m_pos = '0;
    endtask

    task automatic test_forward_full();
        int dc;
        do_reset();
        drive_move(1'b1, 1'b0, 4, 4, 1'b0, dc);
        score_move(dc, 0, 0, dc + 4);
        total += 3;
        if (coils_obs !== 4'b0000) begin bad++; $display("FAIL fwd_idle_coils: %b, required 0000", coils_obs); end
        if (position !== 32'sd4)   begin bad++; $display("FAIL fwd_pos: %0d, required 4", position); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL fwd_busy: %b, required 0", busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_width: done=%b a cycle later, required 0", done); end
    endtask

    task automatic test_reverse_half();
        int dc;
        do_reset();
        drive_move(1'b0, 1'b1, 2, 3, 1'b0, dc);
        score_move(dc, 0, 0, dc + 4);
        total++;
        if (position !== -32'sd3) begin bad++; $display("FAIL rev_pos: %0d, required -3", position); end
    endtask

    task automatic test_mode_switch();
        int dc;
        do_reset();
        drive_move(1'b1, 1'b1, 2, 1, 1'b1, dc);
        score_move(dc, 0, 0, dc + 4);
        total++;
        if (coils_obs !== 4'b0010) begin bad++; $display("FAIL half_hold: %b, required 0010", coils_obs); end
        drive_move(1'b1, 1'b0, 2, 1, 1'b1, dc);
        score_move(dc, 0, 0, dc + 4);
        total += 2;
        if (coils_obs !== 4'b0110) begin bad++; $display("FAIL realign: %b, required 0110", coils_obs); end
        if (position !== 32'sd2)   begin bad++; $display("FAIL mode_pos: %0d, required 2", position); end
    endtask

    task automatic test_period_clamp();
        int dc;
        do_reset();
        drive_move(1'b1, 1'b0, 0, 2, 1'b0, dc);
        score_move(dc, 0, 0, dc + 4);
        total++;
        if (position !== 32'sd2) begin bad++; $display("FAIL clamp_pos: %0d, required 2", position); end
    endtask

    task automatic test_zero_steps();
        int dc;
        drive_move(1'b1, 1'b0, 4, 0, 1'b0, dc);
        score_move(dc, 0, 0, dc + 4);
        total += 2;
        if (busy !== 1'b0)     begin bad++; $display("FAIL zero_busy: %b, required 0", busy); end
        if (position !== m_pos) begin bad++; $display("FAIL zero_pos: %0d, required %0d", position, m_pos); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_abort();
        int dc;
        bit saw_done;
        do_reset();
        drive_move(1'b1, 1'b0, 4, 10, 1'b0, dc);
        score_move(-1, 7, 0, 20);
        total += 2;
        if (position !== 32'sd2) begin bad++; $display("FAIL abort_pos: %0d, required 2", position); end
        if (done !== 1'b0)       begin bad++; $display("FAIL abort_done: %b, required 0", done); end
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total += 2;
        if (saw_done)              begin bad++; $display("FAIL abort_quiet: busy/done seen after abort, required none"); end
        if (coils_obs !== 4'b0000) begin bad++; $display("FAIL abort_coils: %b, required 0000", coils_obs); end
    endtask

    task automatic test_start_in_run();
        int dc;
        do_reset();
        drive_move(1'b1, 1'b0, 3, 3, 1'b0, dc);
        score_move(dc, 0, 4, dc + 4);
        total++;
        if (position !== 32'sd3) begin bad++; $display("FAIL restart_pos: %0d, required 3", position); end
    endtask

    task automatic test_start_abort_idle();
        bit moved;
        bit coil_change;
        hold_en = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        abort  = 1'b1;
        dir    = 1'b1;
        period = 16'd2;
        steps  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        moved       = 1'b0;
        coil_change = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1 || done === 1'b1) moved = 1'b1;
            if (coils_obs !== tbl[m_idx]) coil_change = 1'b1;
            @(negedge clk);
        end
        total += 3;
        if (moved)              begin bad++; $display("FAIL start_abort_move: busy/done seen, required none"); end
        if (coil_change)        begin bad++; $display("FAIL start_abort_coils: %b, required %b", coils_obs, tbl[m_idx]); end
        if (position !== m_pos) begin bad++; $display("FAIL start_abort_pos: %0d, required %0d", position, m_pos); end
    endtask

    task automatic test_back_to_back();
        int dc;
        bit d;
        bit h;
        bit hold;
        int p;
        int s;
        for (int n = 0; n < 8; n++) begin
            d    = 1'($urandom_range(0, 1));
            h    = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            p    = $urandom_range(0, 5);
            s    = $urandom_range(0, 6);
            drive_move(d, h, p, s, hold, dc);
            score_move(dc, 0, 0, dc + 4);
            total += 2;
            if (position !== m_pos) begin
                bad++;
                $display("FAIL b2b_pos[%0d]: %0d, required %0d", n, position, m_pos);
            end
            if (coils_obs !== (hold ? tbl[m_idx] : 4'b0000)) begin
                bad++;
                $display("FAIL b2b_idle_coils[%0d]: %b, required %b", n, coils_obs,
                         hold ? tbl[m_idx] : 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        int dc;
        do_reset();
        drive_move(1'b1, 1'b0, 4, 10, 1'b0, dc);
        for (int k = 0; k < 6; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total += 4;
        if (busy !== 1'b0)         begin bad++; $display("FAIL midreset_busy: %b, required 0", busy); end
        if (position !== 32'sd0)   begin bad++; $display("FAIL midreset_pos: %0d, required 0", position); end
        if (coils_obs !== 4'b0000) begin bad++; $display("FAIL midreset_coils: %b, required 0000", coils_obs); end
        if (done !== 1'b0)         begin bad++; $display("FAIL midreset_done: %b, required 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        hold_en = 1'b1;
        @(negedge clk);
        total++;
        if (coils_obs !== 4'b1010) begin bad++; $display("FAIL midreset_idx: %b, required 1010", coils_obs); end
        m_idx = 1;
        m_pos = '0;
        flush_sb();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        dir       = 1'b0;
        half_step = 1'b0;
        hold_en   = 1'b0;
        period    = '0;
        steps     = '0;
        m_idx     = 1;
        m_pos     = '0;
        cur_dir   = 1'b0;

        test_reset();
        test_forward_full();
        test_reverse_half();
        test_mode_switch();
        test_period_clamp();
        test_zero_steps();
        test_abort();
        test_start_in_run();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_mid_move();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
